// File: rtl/spsram_arbiter_pkg.sv
// spsram_arbiter_pkg: shared FSM states, strobe levels and requester count
package spsram_arbiter_pkg;
  localparam int NREQ = 2;
  localparam logic SRAM_EN = 1'b0;
  localparam logic SRAM_DIS = 1'b1;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/spsram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter holding the last-grant pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic last;
  // on contention favour the requester that was not served last
  always_comb gnt = (&req) ? (last ? 2'b01 : 2'b10) : req;
  // remember who won the most recent accepted transfer
  always_ff @(posedge clk)
    if (rst) last <= 1'b0;
    else if (accept) last <= gnt[1];
endmodule

// File: rtl/spsram_arbiter.sv
// spsram_arbiter: round-robin front end clearing and serving a 2-bank single-port SRAM
module spsram_arbiter
  import spsram_arbiter_pkg::*;
#(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_req_valid,
  input  logic [1:0]           i_req_wen,
  input  logic [2*BW_ADDR-1:0] i_req_addr,
  input  logic [2*BW_DATA-1:0] i_req_data,
  output logic [1:0]           o_req_ready,
  output logic [1:0]           o_rsp_valid,
  output logic [BW_DATA-1:0]   o_rsp_data,
  output logic                 o_init_done,
  output logic [BW_ADDR-2:0]   o_sram_addr,
  output logic [BW_DATA-1:0]   o_sram_data,
  output logic [1:0]           o_sram_cen,
  output logic                 o_sram_wen,
  output logic [1:0]           o_sram_oen,
  input  logic [2*BW_DATA-1:0] i_sram_rdata
);
  state_t state, state_nxt;
  logic [BW_ADDR-1:0] cnt, cmd_addr;
  logic [BW_DATA-1:0] cmd_data;
  logic [1:0] gnt;
  logic acc, id, cmd_v, cmd_wr;
  logic s1_rd, s1_bank, s1_id, s2_bank;
  rr_arb2 u_arb (
    .clk(i_clk),
    .rst(i_rst),
    .req(i_req_valid & {NREQ{o_init_done}}),
    .accept(acc),
    .gnt(gnt)
  );
  assign o_req_ready = gnt;
  assign acc = |gnt;
  assign id = gnt[1];
  // pick the command for the next SRAM cycle: clear sweep during init, granted request after
  always_comb begin
    state_nxt = state;
    cmd_v = acc;
    cmd_wr = i_req_wen[id];
    cmd_addr = id ? i_req_addr[2*BW_ADDR-1:BW_ADDR] : i_req_addr[BW_ADDR-1:0];
    cmd_data = id ? i_req_data[2*BW_DATA-1:BW_DATA] : i_req_data[BW_DATA-1:0];
    if (state == ST_INIT) begin
      cmd_v = 1'b1;
      cmd_wr = 1'b1;
      cmd_addr = cnt;
      cmd_data = '0;
      state_nxt = (&cnt) ? ST_RUN : ST_INIT;
    end
  end
  // state register, sweep counter and init flag lagging the sweep's last write
  always_ff @(posedge i_clk) begin
    state <= i_rst ? ST_INIT : state_nxt;
    cnt <= i_rst ? '0 : (state == ST_INIT) ? cnt + 1'b1 : cnt;
    o_init_done <= ~i_rst & (state == ST_RUN);
  end
  // command stage drives the SRAM, response stage tracks returning reads
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sram_cen <= {2{SRAM_DIS}};
      o_sram_wen <= SRAM_DIS;
      o_sram_addr <= '0;
      o_sram_data <= '0;
      s1_rd <= 1'b0;
      s1_bank <= 1'b0;
      s1_id <= 1'b0;
      o_rsp_valid <= 2'b00;
      s2_bank <= 1'b0;
    end else begin
      o_sram_cen <= !cmd_v ? {2{SRAM_DIS}} : cmd_addr[BW_ADDR-1] ? {SRAM_EN, SRAM_DIS} : {SRAM_DIS, SRAM_EN};
      o_sram_wen <= (cmd_v & cmd_wr) ? SRAM_EN : SRAM_DIS;
      o_sram_addr <= cmd_v ? cmd_addr[BW_ADDR-2:0] : o_sram_addr;
      o_sram_data <= cmd_v ? cmd_data : o_sram_data;
      s1_rd <= cmd_v & ~cmd_wr;
      s1_bank <= cmd_addr[BW_ADDR-1];
      s1_id <= id;
      o_rsp_valid <= {s1_rd & s1_id, s1_rd & ~s1_id};
      s2_bank <= s1_bank;
    end
  end
  assign o_sram_oen = !(|o_rsp_valid) ? {2{SRAM_DIS}} : s2_bank ? {SRAM_EN, SRAM_DIS} : {SRAM_DIS, SRAM_EN};
  assign o_rsp_data = !(|o_rsp_valid) ? '0 : s2_bank ? i_sram_rdata[2*BW_DATA-1:BW_DATA] : i_sram_rdata[BW_DATA-1:0];
endmodule
